// File: rtl/alarm_clock_pkg.sv
// Shared definitions for the alarm clock setting path: FSM states, digit
// limits, edit-digit codes and a bounded digit increment helper.
package alarm_clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EDIT_H1 = 3'd1,
    ST_EDIT_H0 = 3'd2,
    ST_EDIT_M1 = 3'd3,
    ST_EDIT_M0 = 3'd4,
    ST_LOAD    = 3'd5
  } state_t;

  localparam logic [1:0] H1_MAX    = 2'd2;
  localparam logic [3:0] H0_MAX    = 4'd9;
  localparam logic [3:0] H0_MAX_H2 = 4'd3;
  localparam logic [3:0] M1_MAX    = 4'd5;
  localparam logic [3:0] M0_MAX    = 4'd9;

  localparam logic [1:0] DIG_H1 = 2'd0;
  localparam logic [1:0] DIG_H0 = 2'd1;
  localparam logic [1:0] DIG_M1 = 2'd2;
  localparam logic [1:0] DIG_M0 = 2'd3;

  // Increment a BCD digit, wrapping to 0 once it has reached max.
  function automatic logic [3:0] wrap_inc(input logic [3:0] val, input logic [3:0] max);
    return (val >= max) ? 4'd0 : val + 4'd1;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for a debounced button level. The pulse is registered,
// so it appears one cycle after the level rises and lasts exactly one cycle.
module btn_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic prev;

  // Remember the previous level and flag a low-to-high transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= level;
      pulse <= level & ~prev;
    end
  end

endmodule

// File: rtl/clock_set_controller.sv
// Button-driven time/alarm setting sequencer. Walks H1,H0,M1,M0 with
// wrap/clamp rules and then holds load_time or load_alarm long enough for the
// clock core's 1 s tick to capture the digit bus.
module clock_set_controller
  import alarm_clock_pkg::*;
#(
  parameter int LOAD_HOLD    = 150_000_000,
  parameter int EDIT_TIMEOUT = 1_000_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_set_time,
  input  logic       btn_set_alarm,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic       btn_cancel,
  input  logic [1:0] cur_hour1,
  input  logic [3:0] cur_hour0,
  input  logic [3:0] cur_min1,
  input  logic [3:0] cur_min0,
  output logic [1:0] hour_in1,
  output logic [3:0] hour_in0,
  output logic [3:0] minute_in1,
  output logic [3:0] minute_in0,
  output logic       load_time,
  output logic       load_alarm,
  output logic       edit_active,
  output logic [1:0] edit_digit,
  output logic       busy
);

  localparam int CNT_MAX = (LOAD_HOLD > EDIT_TIMEOUT) ? LOAD_HOLD : EDIT_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LOAD_HOLD - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(EDIT_TIMEOUT - 1);

  logic ev_set_time, ev_set_alarm, ev_inc, ev_next, ev_cancel, any_ev;

  btn_edge_detect u_ed_set_time  (.clock(clock), .reset(reset), .level(btn_set_time),  .pulse(ev_set_time));
  btn_edge_detect u_ed_set_alarm (.clock(clock), .reset(reset), .level(btn_set_alarm), .pulse(ev_set_alarm));
  btn_edge_detect u_ed_inc       (.clock(clock), .reset(reset), .level(btn_inc),       .pulse(ev_inc));
  btn_edge_detect u_ed_next      (.clock(clock), .reset(reset), .level(btn_next),      .pulse(ev_next));
  btn_edge_detect u_ed_cancel    (.clock(clock), .reset(reset), .level(btn_cancel),    .pulse(ev_cancel));

  assign any_ev = ev_set_time | ev_set_alarm | ev_inc | ev_next | ev_cancel;

  state_t           state;
  logic             tgt;
  logic [1:0]       h1;
  logic [3:0]       h0, m1, m0;
  logic [1:0]       a_h1;
  logic [3:0]       a_h0, a_m1, a_m0;
  logic [CNT_W-1:0] cnt;

  // Setting FSM: edit digits, alarm shadow, shared hold/timeout counter and load strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      tgt        <= 1'b0;
      h1         <= '0;
      h0         <= '0;
      m1         <= '0;
      m0         <= '0;
      a_h1       <= '0;
      a_h0       <= '0;
      a_m1       <= '0;
      a_m0       <= '0;
      cnt        <= '0;
      load_time  <= 1'b0;
      load_alarm <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          load_time  <= 1'b0;
          load_alarm <= 1'b0;
          cnt        <= '0;
          if (ev_set_time) begin
            state <= ST_EDIT_H1;
            tgt   <= 1'b0;
            h1    <= cur_hour1;
            h0    <= cur_hour0;
            m1    <= cur_min1;
            m0    <= cur_min0;
          end else if (ev_set_alarm) begin
            state <= ST_EDIT_H1;
            tgt   <= 1'b1;
            h1    <= a_h1;
            h0    <= a_h0;
            m1    <= a_m1;
            m0    <= a_m0;
          end
        end

        ST_EDIT_H1, ST_EDIT_H0, ST_EDIT_M1, ST_EDIT_M0: begin
          if (ev_cancel) begin
            state <= ST_IDLE;
            cnt   <= '0;
            h1    <= '0;
            h0    <= '0;
            m1    <= '0;
            m0    <= '0;
          end else if (ev_next) begin
            cnt <= '0;
            case (state)
              ST_EDIT_H1: state <= ST_EDIT_H0;
              ST_EDIT_H0: state <= ST_EDIT_M1;
              ST_EDIT_M1: state <= ST_EDIT_M0;
              ST_EDIT_M0: begin
                state      <= ST_LOAD;
                load_time  <= ~tgt;
                load_alarm <= tgt;
                if (tgt) begin
                  a_h1 <= h1;
                  a_h0 <= h0;
                  a_m1 <= m1;
                  a_m0 <= m0;
                end
              end
              default: state <= ST_IDLE;
            endcase
          end else if (ev_inc) begin
            cnt <= '0;
            case (state)
              ST_EDIT_H1: begin
                if (h1 >= H1_MAX) begin
                  h1 <= 2'd0;
                end else begin
                  h1 <= h1 + 2'd1;
                  // Moving into the 20s: hours above 23 would be invalid.
                  if ((h1 == H1_MAX - 2'd1) && (h0 > H0_MAX_H2)) h0 <= H0_MAX_H2;
                end
              end
              ST_EDIT_H0: h0 <= wrap_inc(h0, (h1 == H1_MAX) ? H0_MAX_H2 : H0_MAX);
              ST_EDIT_M1: m1 <= wrap_inc(m1, M1_MAX);
              ST_EDIT_M0: m0 <= wrap_inc(m0, M0_MAX);
              default: ;
            endcase
          end else if (any_ev) begin
            cnt <= '0;
          end else if (cnt == TO_LAST) begin
            // User walked away: abandon the edit without loading anything.
            state <= ST_IDLE;
            cnt   <= '0;
            h1    <= '0;
            h0    <= '0;
            m1    <= '0;
            m0    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_LOAD: begin
          if (cnt == HOLD_LAST) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            load_time  <= 1'b0;
            load_alarm <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decode which digit is being edited for the display blinker.
  always_comb begin
    edit_digit = DIG_H1;
    case (state)
      ST_EDIT_H0: edit_digit = DIG_H0;
      ST_EDIT_M1: edit_digit = DIG_M1;
      ST_EDIT_M0: edit_digit = DIG_M0;
      default:    edit_digit = DIG_H1;
    endcase
  end

  assign edit_active = (state == ST_EDIT_H1) || (state == ST_EDIT_H0) ||
                       (state == ST_EDIT_M1) || (state == ST_EDIT_M0);
  assign busy        = (state == ST_LOAD);
  assign hour_in1    = h1;
  assign hour_in0    = h0;
  assign minute_in1  = m1;
  assign minute_in0  = m0;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with short hold/timeout values.
module tb_clock_set_controller;

  localparam int B_TIME   = 0;
  localparam int B_ALARM  = 1;
  localparam int B_INC    = 2;
  localparam int B_NEXT   = 3;
  localparam int B_CANCEL = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_set_time, btn_set_alarm, btn_inc, btn_next, btn_cancel;
  logic [1:0] cur_hour1;
  logic [3:0] cur_hour0, cur_min1, cur_min0;
  logic [1:0] hour_in1;
  logic [3:0] hour_in0, minute_in1, minute_in0;
  logic       load_time, load_alarm, edit_active, busy;
  logic [1:0] edit_digit;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  clock_set_controller #(.LOAD_HOLD(4), .EDIT_TIMEOUT(20)) dut (
    .clock(clock), .reset(reset),
    .btn_set_time(btn_set_time), .btn_set_alarm(btn_set_alarm),
    .btn_inc(btn_inc), .btn_next(btn_next), .btn_cancel(btn_cancel),
    .cur_hour1(cur_hour1), .cur_hour0(cur_hour0), .cur_min1(cur_min1), .cur_min0(cur_min0),
    .hour_in1(hour_in1), .hour_in0(hour_in0), .minute_in1(minute_in1), .minute_in0(minute_in0),
    .load_time(load_time), .load_alarm(load_alarm), .edit_active(edit_active),
    .edit_digit(edit_digit), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected bus given as a 4-digit hex word, e.g. 16'h1347 for 13:47.
  task automatic check_bus(input string tag, input logic [15:0] exp);
    check(tag, {16'h0, 2'b00, hour_in1, hour_in0, minute_in1, minute_in0}, {16'h0, exp});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_TIME:   btn_set_time  = v;
      B_ALARM:  btn_set_alarm = v;
      B_INC:    btn_inc       = v;
      B_NEXT:   btn_next      = v;
      default:  btn_cancel    = v;
    endcase
  endtask

  // One-cycle press; returns on the negedge after the FSM has reacted.
  task automatic press(input int b);
    set_btn(b, 1'b1);
    step(1);
    set_btn(b, 1'b0);
    step(1);
  endtask

  task automatic set_cur(input logic [15:0] t);
    cur_hour1 = t[13:12];
    cur_hour0 = t[11:8];
    cur_min1  = t[7:4];
    cur_min0  = t[3:0];
  endtask

  initial begin
    reset = 1'b1;
    btn_set_time = 0; btn_set_alarm = 0; btn_inc = 0; btn_next = 0; btn_cancel = 0;
    set_cur(16'h0000);
    step(3);
    reset = 1'b0;

    // Reset state
    check("rst_edit_active", edit_active, 0);
    check("rst_busy", busy, 0);
    check("rst_load_time", load_time, 0);
    check("rst_load_alarm", load_alarm, 0);
    check("rst_edit_digit", edit_digit, 0);
    check_bus("rst_bus", 16'h0000);

    // Time edit seeded from 13:47, committed unchanged
    set_cur(16'h1347);
    press(B_TIME);
    check("t_edit_active", edit_active, 1);
    check("t_digit_h1", edit_digit, 0);
    check_bus("t_seed_bus", 16'h1347);
    press(B_NEXT);
    check("t_digit_h0", edit_digit, 1);
    press(B_NEXT);
    check("t_digit_m1", edit_digit, 2);
    press(B_NEXT);
    check("t_digit_m0", edit_digit, 3);
    press(B_NEXT);
    for (int i = 0; i < 4; i++) begin
      check("t_load_time_hi", load_time, 1);
      check("t_load_alarm_lo", load_alarm, 0);
      check("t_busy_hi", busy, 1);
      check_bus("t_load_bus", 16'h1347);
      step(1);
    end
    check("t_load_time_end", load_time, 0);
    check("t_busy_end", busy, 0);
    check("t_edit_after_load", edit_active, 0);

    // Alarm edit: H1 0->2, H0 wraps within 0..3
    press(B_ALARM);
    check_bus("a_seed_bus", 16'h0000);
    check("a_edit_active", edit_active, 1);
    press(B_INC);
    press(B_INC);
    check_bus("a_h1_2", 16'h2000);
    press(B_NEXT);
    for (int i = 0; i < 5; i++) press(B_INC);
    check_bus("a_h0_wrap_5", 16'h2100);
    press(B_INC);
    press(B_INC);
    check_bus("a_h0_3", 16'h2300);
    press(B_NEXT);
    press(B_NEXT);
    press(B_NEXT);
    check("a_load_alarm_1", load_alarm, 1);
    check("a_load_time_lo", load_time, 0);
    // inc during LOAD must be ignored and not disturb the hold count
    btn_inc = 1'b1;
    step(1);
    btn_inc = 1'b0;
    check("a_load_alarm_2", load_alarm, 1);
    step(1);
    check("a_load_alarm_3", load_alarm, 1);
    step(1);
    check("a_load_alarm_4", load_alarm, 1);
    check_bus("a_load_bus_frozen", 16'h2300);
    step(1);
    check("a_load_alarm_end", load_alarm, 0);
    check("a_busy_end", busy, 0);
    check("a_no_edit_after", edit_active, 0);
    press(B_ALARM);
    check_bus("a_reseed_2300", 16'h2300);
    press(B_CANCEL);
    check("a_cancel_idle", edit_active, 0);
    check_bus("a_cancel_bus", 16'h0000);

    // Clamp: 19:59, H1 1->2 forces H0 9->3; M0 9 wraps to 0 without carry
    set_cur(16'h1959);
    press(B_TIME);
    check_bus("c_seed", 16'h1959);
    press(B_INC);
    check_bus("c_clamp", 16'h2359);
    press(B_NEXT);
    press(B_NEXT);
    press(B_NEXT);
    press(B_INC);
    check_bus("c_m0_wrap", 16'h2350);
    press(B_CANCEL);
    check("c_cancel", edit_active, 0);

    // cancel+next+inc together in EDIT_M1: cancel wins
    press(B_TIME);
    press(B_NEXT);
    press(B_NEXT);
    check("p_at_m1", edit_digit, 2);
    btn_cancel = 1; btn_next = 1; btn_inc = 1;
    step(1);
    btn_cancel = 0; btn_next = 0; btn_inc = 0;
    step(1);
    check("p_idle", edit_active, 0);
    check("p_no_busy", busy, 0);
    check("p_no_load", load_time, 0);
    check_bus("p_bus_zero", 16'h0000);
    step(1);
    check("p_still_no_load", load_time | load_alarm, 0);

    // Edit timeout after 20 idle cycles
    press(B_TIME);
    step(19);
    check("to_before", edit_active, 1);
    step(1);
    check("to_after", edit_active, 0);
    check("to_no_load", load_time | load_alarm | busy, 0);

    // Held inc for 10 cycles counts once
    press(B_TIME);
    btn_inc = 1'b1;
    step(10);
    btn_inc = 1'b0;
    step(2);
    check_bus("h_single_inc", 16'h2359);
    check("h_digit", edit_digit, 0);
    press(B_CANCEL);

    // Reset in the middle of LOAD
    set_cur(16'h1347);
    press(B_TIME);
    press(B_NEXT);
    press(B_NEXT);
    press(B_NEXT);
    press(B_NEXT);
    check("r_load_on", load_time, 1);
    step(1);
    reset = 1'b1;
    step(1);
    check("r_load_time_off", load_time, 0);
    check("r_load_alarm_off", load_alarm, 0);
    check("r_busy_off", busy, 0);
    check("r_edit_off", edit_active, 0);
    check_bus("r_bus_zero", 16'h0000);
    reset = 1'b0;
    press(B_ALARM);
    check_bus("r_shadow_cleared", 16'h0000);
    press(B_CANCEL);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
